// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU program sequencer: opcodes, FSM states and
// instruction field layout.
package alu_sequencer_pkg;

   // Instruction layout: [6:4] opcode, [3:0] data operand
   localparam int INSTR_W  = 7;
   localparam int OP_MSB   = 6;
   localparam int OP_LSB   = 4;
   localparam int DATA_MSB = 3;
   localparam int DATA_LSB = 0;

   // ALU opcodes, forwarded untouched to the ALU
   localparam logic [2:0] OP_ADDC = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SEXT = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_SHL  = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;
   localparam logic [2:0] OP_HOLD = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLR   = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   function automatic logic [2:0] instr_op(input logic [INSTR_W-1:0] instr);
      return instr[OP_MSB:OP_LSB];
   endfunction

   function automatic logic [3:0] instr_data(input logic [INSTR_W-1:0] instr);
      return instr[DATA_MSB:DATA_LSB];
   endfunction

endpackage

// File: rtl/alu_sequencer_prog_mem.sv
// Program buffer: DEPTH x 7 register file, one synchronous write port and one
// asynchronous read port. Storage is deliberately not reset.
module alu_prog_mem
   import alu_sequencer_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
)
(
   input  logic               i_clk,
   input  logic               i_we,
   input  logic [ADDR_W-1:0]  i_waddr,
   input  logic [INSTR_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0]  i_raddr,
   output logic [INSTR_W-1:0] o_rdata
);

   logic [INSTR_W-1:0] r_mem [DEPTH];

   // Write one instruction per cycle when enabled
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_sequencer.sv
// Sequencer that replays a loaded program into the 8-bit accumulator ALU:
// clears the ALU, issues one instruction per cycle, captures the final value.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
)
(
   input  logic               Clock,
   input  logic               Reset_b,
   input  logic               LoadEn,
   input  logic [INSTR_W-1:0] LoadInstr,
   input  logic               Start,
   input  logic               Clear,
   input  logic [7:0]         ALUin,
   output logic [2:0]         Function,
   output logic [3:0]         Data,
   output logic               AluReset_b,
   output logic [7:0]         Result,
   output logic [ADDR_W:0]    Count,
   output logic               Full,
   output logic               Busy,
   output logic               Done,
   output logic               LoadErr
);

   localparam logic [ADDR_W:0] CNT_ZERO = {(ADDR_W+1){1'b0}};
   localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0] CNT_FULL = CNT_ONE << ADDR_W;

   state_t              r_state;
   logic [ADDR_W:0]     r_count;
   logic [ADDR_W:0]     r_rd_ptr;
   logic [2:0]          r_function;
   logic [3:0]          r_data;
   logic                r_alu_rst_b;
   logic [7:0]          r_result;
   logic                r_full;
   logic                r_busy;
   logic                r_done;
   logic                r_load_err;

   logic                w_start_ok;
   logic                w_load_ok;
   logic                w_load_drop;
   logic [ADDR_W:0]     w_count_inc;
   logic [INSTR_W-1:0]  w_rd_instr;

   // IDLE command decode: Clear beats Start, Start beats LoadEn
   always_comb begin
      w_start_ok  = 1'b0;
      w_load_ok   = 1'b0;
      w_load_drop = 1'b0;
      w_count_inc = r_count + CNT_ONE;
      if ((r_state == ST_IDLE) && !Clear) begin
         if (Start && (r_count != CNT_ZERO)) begin
            w_start_ok = 1'b1;
         end else if (LoadEn) begin
            w_load_ok   = !r_full;
            w_load_drop = r_full;
         end else begin
            w_start_ok = 1'b0;
         end
      end else begin
         w_start_ok = 1'b0;
      end
   end

   alu_prog_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_prog_mem (
      .i_clk   (Clock),
      .i_we    (w_load_ok),
      .i_waddr (r_count[ADDR_W-1:0]),
      .i_wdata (LoadInstr),
      .i_raddr (r_rd_ptr[ADDR_W-1:0]),
      .o_rdata (w_rd_instr)
   );

   // Sequencer FSM with all ALU-facing and status outputs registered
   always_ff @(posedge Clock or negedge Reset_b) begin
      if (!Reset_b) begin
         r_state     <= ST_IDLE;
         r_count     <= CNT_ZERO;
         r_rd_ptr    <= CNT_ZERO;
         r_function  <= OP_HOLD;
         r_data      <= 4'd0;
         r_alu_rst_b <= 1'b0;
         r_result    <= 8'd0;
         r_full      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_load_err  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_function  <= OP_HOLD;
               r_data      <= 4'd0;
               r_alu_rst_b <= 1'b1;
               r_busy      <= 1'b0;
               r_done      <= 1'b0;
               if (Clear) begin
                  r_count    <= CNT_ZERO;
                  r_full     <= 1'b0;
                  r_load_err <= 1'b0;
               end else if (w_start_ok) begin
                  r_state     <= ST_CLR;
                  r_rd_ptr    <= CNT_ZERO;
                  r_busy      <= 1'b1;
                  r_alu_rst_b <= 1'b0;
               end else if (w_load_ok) begin
                  r_count <= w_count_inc;
                  r_full  <= (w_count_inc == CNT_FULL);
               end else if (w_load_drop) begin
                  r_load_err <= 1'b1;
               end
            end
            ST_CLR: begin
               // ALU is cleared on this edge; first instruction goes out with it
               r_alu_rst_b <= 1'b1;
               r_function  <= instr_op(w_rd_instr);
               r_data      <= instr_data(w_rd_instr);
               r_rd_ptr    <= r_rd_ptr + CNT_ONE;
               r_state     <= ST_RUN;
               if (LoadEn) begin
                  r_load_err <= 1'b1;
               end
            end
            ST_RUN: begin
               if (r_rd_ptr == r_count) begin
                  r_function <= OP_HOLD;
                  r_data     <= 4'd0;
                  r_state    <= ST_DRAIN;
               end else begin
                  r_function <= instr_op(w_rd_instr);
                  r_data     <= instr_data(w_rd_instr);
                  r_rd_ptr   <= r_rd_ptr + CNT_ONE;
               end
               if (LoadEn) begin
                  r_load_err <= 1'b1;
               end
            end
            ST_DRAIN: begin
               // ALUin now holds the effect of the last issued instruction
               r_result <= ALUin;
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
               r_state  <= ST_DONE;
               if (LoadEn) begin
                  r_load_err <= 1'b1;
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
               if (LoadEn) begin
                  r_load_err <= 1'b1;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_function  <= OP_HOLD;
               r_data      <= 4'd0;
               r_alu_rst_b <= 1'b1;
               r_busy      <= 1'b0;
               r_done      <= 1'b0;
            end
         endcase
      end
   end

   assign Function   = r_function;
   assign Data       = r_data;
   assign AluReset_b = r_alu_rst_b;
   assign Result     = r_result;
   assign Count      = r_count;
   assign Full       = r_full;
   assign Busy       = r_busy;
   assign Done       = r_done;
   assign LoadErr    = r_load_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a stand-in for the team ALU.
module tb_alu_sequencer;

   logic       Clock;
   logic       Reset_b;
   logic       LoadEn;
   logic [6:0] LoadInstr;
   logic       Start;
   logic       Clear;
   logic [7:0] ALUin;
   logic [2:0] Function;
   logic [3:0] Data;
   logic       AluReset_b;
   logic [7:0] Result;
   logic [3:0] Count;
   logic       Full;
   logic       Busy;
   logic       Done;
   logic       LoadErr;

   alu_sequencer #(.DEPTH(8), .ADDR_W(3)) dut (
      .Clock      (Clock),
      .Reset_b    (Reset_b),
      .LoadEn     (LoadEn),
      .LoadInstr  (LoadInstr),
      .Start      (Start),
      .Clear      (Clear),
      .ALUin      (ALUin),
      .Function   (Function),
      .Data       (Data),
      .AluReset_b (AluReset_b),
      .Result     (Result),
      .Count      (Count),
      .Full       (Full),
      .Busy       (Busy),
      .Done       (Done),
      .LoadErr    (LoadErr)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Accumulator ALU behaviour
   function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [2:0] f, input logic [3:0] d);
      case (f)
         3'b000: return {3'b000, ({1'b0, a[3:0]} + {1'b0, d})};
         3'b001: return a + {4'b0000, d};
         3'b010: return {{4{a[3]}}, a[3:0]};
         3'b011: return {7'd0, |a};
         3'b100: return {7'd0, &a};
         3'b101: return {a[6:0], 1'b0};
         3'b110: return {4'b0000, a[3:0]} * {4'b0000, d};
         default: return a;
      endcase
   endfunction

   // Stand-in ALU: registered accumulator with synchronous active-low clear
   logic [7:0] alu_q;
   always @(posedge Clock) begin
      if (!AluReset_b) alu_q <= 8'h00;
      else             alu_q <= alu_f(alu_q, Function, Data);
   end
   assign ALUin = alu_q;

   // ---------------- behavioural model ----------------
   logic [6:0] prog_m [8];
   int         m_cnt;
   int         m_t;        // 0 = idle, otherwise cycle number since accepted Start
   logic       m_err;
   logic [7:0] m_result;
   logic [7:0] m_final;
   logic       m_rst_pend;

   function automatic logic [7:0] run_prog(input int n);
      logic [7:0] acc;
      acc = 8'h00;
      for (int i = 0; i < n; i++) acc = alu_f(acc, prog_m[i][6:4], prog_m[i][3:0]);
      return acc;
   endfunction

   always @(posedge Clock or negedge Reset_b) begin
      if (!Reset_b) begin
         m_cnt      <= 0;
         m_t        <= 0;
         m_err      <= 1'b0;
         m_result   <= 8'h00;
         m_rst_pend <= 1'b1;
      end else begin
         m_rst_pend <= 1'b0;
         if (m_t == 0) begin
            if (Clear) begin
               m_cnt <= 0;
               m_err <= 1'b0;
            end else if (Start && m_cnt > 0) begin
               m_t     <= 1;
               m_final <= run_prog(m_cnt);
            end else if (LoadEn) begin
               if (m_cnt == 8) m_err <= 1'b1;
               else begin
                  prog_m[m_cnt[2:0]] <= LoadInstr;
                  m_cnt <= m_cnt + 1;
               end
            end
         end else begin
            if (LoadEn) m_err <= 1'b1;
            if (m_t == m_cnt + 2) m_result <= m_final;
            m_t <= (m_t == m_cnt + 3) ? 0 : m_t + 1;
         end
      end
   end

   // ---------------- checking ----------------
   int   n_checks = 0;
   int   n_fail   = 0;
   logic chk_en   = 1'b0;
   logic s_busy, s_done, s_arst;
   logic [7:0] s_alu;
   logic [7:0] aluv [16];

   task automatic hchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cmp_all();
      logic [2:0] ef;
      logic [3:0] ed;
      int         idx;
      ef = 3'b111;
      ed = 4'd0;
      if (m_t >= 2 && m_t <= m_cnt + 1) begin
         idx = m_t - 2;
         ef  = prog_m[idx[2:0]][6:4];
         ed  = prog_m[idx[2:0]][3:0];
      end
      hchk("cyc_function", 32'(Function),   32'(ef));
      hchk("cyc_data",     32'(Data),       32'(ed));
      hchk("cyc_alureset", 32'(AluReset_b), 32'(!(m_rst_pend || m_t == 1)));
      hchk("cyc_result",   32'(Result),     32'(m_result));
      hchk("cyc_count",    32'(Count),      32'(m_cnt));
      hchk("cyc_full",     32'(Full),       32'(m_cnt == 8));
      hchk("cyc_busy",     32'(Busy),       32'(m_t >= 1 && m_t <= m_cnt + 2));
      hchk("cyc_done",     32'(Done),       32'(m_t == m_cnt + 3));
      hchk("cyc_loaderr",  32'(LoadErr),    32'(m_err));
   endtask

   // One clock: sample and compare at the falling edge, return just after the rising edge
   task automatic cyc();
      @(negedge Clock);
      s_busy = Busy;
      s_done = Done;
      s_arst = AluReset_b;
      s_alu  = ALUin;
      if (chk_en) cmp_all();
      @(posedge Clock);
      #1;
   endtask

   task automatic load(input logic [6:0] ins);
      LoadEn    = 1'b1;
      LoadInstr = ins;
      cyc();
      LoadEn    = 1'b0;
   endtask

   task automatic do_clear();
      Clear = 1'b1;
      cyc();
      Clear = 1'b0;
   endtask

   task automatic run(input int win, output int nb, output int nd, output int na);
      Start = 1'b1;
      cyc();
      Start = 1'b0;
      nb = 0; nd = 0; na = 0;
      for (int i = 0; i < win; i++) begin
         cyc();
         nb = nb + (s_busy ? 1 : 0);
         nd = nd + (s_done ? 1 : 0);
         na = na + (s_arst ? 0 : 1);
         aluv[i] = s_alu;
      end
   endtask

   int nb, nd, na;

   initial begin
      Reset_b = 1'b0; LoadEn = 1'b0; LoadInstr = 7'd0; Start = 1'b0; Clear = 1'b0;
      @(posedge Clock); #1;
      chk_en = 1'b1;
      cyc();
      hchk("rst_function", 32'(Function),   32'(3'b111));
      hchk("rst_data",     32'(Data),       32'(4'd0));
      hchk("rst_alureset", 32'(AluReset_b), 32'(1'b0));
      hchk("rst_result",   32'(Result),     32'(8'h00));
      hchk("rst_count",    32'(Count),      32'(4'd0));
      hchk("rst_busy",     32'(Busy),       32'(1'b0));
      hchk("rst_done",     32'(Done),       32'(1'b0));
      hchk("rst_loaderr",  32'(LoadErr),    32'(1'b0));
      Reset_b = 1'b1;
      cyc();
      hchk("rel_alureset", 32'(AluReset_b), 32'(1'b1));

      // Two add-with-carry steps: 3 + 5
      load(7'b000_0011);
      load(7'b000_0101);
      run(6, nb, nd, na);
      hchk("t1_busy_cycles", 32'(nb), 32'(4));
      hchk("t1_done_pulses", 32'(nd), 32'(1));
      hchk("t1_alurst_low",  32'(na), 32'(1));
      hchk("t1_result",      32'(Result), 32'(8'h08));

      // add 4 then multiply by 3, replayed twice
      do_clear();
      load(7'b001_0100);
      load(7'b110_0011);
      run(6, nb, nd, na);
      hchk("t2_result",      32'(Result), 32'(8'h0C));
      run(6, nb, nd, na);
      hchk("t2_replay_res",  32'(Result), 32'(8'h0C));
      hchk("t2_replay_done", 32'(nd), 32'(1));

      // 9 + 9 then sign-extend the low nibble
      do_clear();
      load(7'b000_1001);
      load(7'b000_1001);
      load(7'b010_0000);
      run(7, nb, nd, na);
      hchk("t3_alu_step1", 32'(aluv[2]), 32'(8'h09));
      hchk("t3_alu_step2", 32'(aluv[3]), 32'(8'h12));
      hchk("t3_result",    32'(Result),  32'(8'h02));
      hchk("t3_busy",      32'(nb),      32'(5));

      // Overfill the buffer, then clear it
      do_clear();
      for (int i = 0; i < 9; i++) load(7'b001_0001);
      hchk("t4_count",   32'(Count),   32'(4'd8));
      hchk("t4_full",    32'(Full),    32'(1'b1));
      hchk("t4_loaderr", 32'(LoadErr), 32'(1'b1));
      do_clear();
      hchk("t4_clr_count",   32'(Count),   32'(4'd0));
      hchk("t4_clr_full",    32'(Full),    32'(1'b0));
      hchk("t4_clr_loaderr", 32'(LoadErr), 32'(1'b0));

      // Start with an empty program is ignored
      run(5, nb, nd, na);
      hchk("t5_empty_busy",   32'(nb),     32'(0));
      hchk("t5_empty_done",   32'(nd),     32'(0));
      hchk("t5_empty_result", 32'(Result), 32'(8'h02));

      // LoadEn during a run is rejected and flagged
      load(7'b001_0010);
      load(7'b001_0011);
      Start = 1'b1;
      cyc();
      Start = 1'b0;
      cyc();
      load(7'b001_0001);
      for (int i = 0; i < 6; i++) cyc();
      hchk("t5_run_loaderr", 32'(LoadErr), 32'(1'b1));
      hchk("t5_run_count",   32'(Count),   32'(4'd2));
      hchk("t5_run_result",  32'(Result),  32'(8'h05));

      // Asynchronous reset in the middle of a run
      do_clear();
      for (int i = 0; i < 4; i++) load(7'b001_0001);
      Start = 1'b1;
      cyc();
      Start = 1'b0;
      cyc();
      cyc();
      #2;
      Reset_b = 1'b0;
      #1;
      hchk("t6_function", 32'(Function),   32'(3'b111));
      hchk("t6_data",     32'(Data),       32'(4'd0));
      hchk("t6_alureset", 32'(AluReset_b), 32'(1'b0));
      hchk("t6_count",    32'(Count),      32'(4'd0));
      hchk("t6_busy",     32'(Busy),       32'(1'b0));
      hchk("t6_result",   32'(Result),     32'(8'h00));
      cyc();
      Reset_b = 1'b1;
      hchk("t6_rel_alurst_low", 32'(AluReset_b), 32'(1'b0));
      cyc();
      hchk("t6_rel_alurst_high", 32'(AluReset_b), 32'(1'b1));
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
